// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single write port of the 32x32 register file between two
// writeback requesters.  Each requester owns a one-entry holding slot fed by
// a valid/ready handshake.  An arbiter drains the slots onto the registered
// write-port outputs at one write per cycle.
//
// Writes to r0 are accepted and then discarded, because r0 is never written.
//
// Build option:
//   RFARB_FIXED_PRIO_EN  When defined, A always wins if both slots are full.
//                        Continuous A traffic can starve B.
//                        When undefined (default), the arbiter alternates
//                        between A and B when both slots are full.
//
// Ports:
//   clk                        rising-edge clock
//   reset                      asynchronous, active-high; clears all state
//   a_valid/a_ready            requester A handshake
//   a_addr/a_data              requester A destination register and data
//   b_valid/b_ready            requester B handshake
//   b_addr/b_data              requester B destination register and data
//   D_En/D_Addr/D              registered register-file write port
//   idle                       both slots empty and no write in flight
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              D_En,
  output logic [ADDR_W-1:0] D_Addr,
  output logic [DATA_W-1:0] D,
  output logic              idle
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  logic              slot_a_full_q, slot_a_full_d;
  logic [ADDR_W-1:0] slot_a_addr_q, slot_a_addr_d;
  logic [DATA_W-1:0] slot_a_data_q, slot_a_data_d;
  logic              slot_b_full_q, slot_b_full_d;
  logic [ADDR_W-1:0] slot_b_addr_q, slot_b_addr_d;
  logic [DATA_W-1:0] slot_b_data_q, slot_b_data_d;
  grant_e            last_grant_q, last_grant_d;
  logic              d_en_q, d_en_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;

  logic grant_a, grant_b;
  logic accept_a, accept_b;

  // Grant depends only on registered slot state, so ready never depends
  // combinationally on valid.
  always_comb begin
`ifdef RFARB_FIXED_PRIO_EN
    grant_a = slot_a_full_q;
`else
    grant_a = slot_a_full_q && (!slot_b_full_q || (last_grant_q == GRANT_B));
`endif
    grant_b = slot_b_full_q && !grant_a;
  end

  // A slot being drained this edge can be refilled on the same edge.
  assign a_ready  = !slot_a_full_q || grant_a;
  assign b_ready  = !slot_b_full_q || grant_b;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  always_comb begin
    slot_a_full_d = slot_a_full_q;
    slot_a_addr_d = slot_a_addr_q;
    slot_a_data_d = slot_a_data_q;
    slot_b_full_d = slot_b_full_q;
    slot_b_addr_d = slot_b_addr_q;
    slot_b_data_d = slot_b_data_q;
    last_grant_d  = last_grant_q;
    d_en_d        = grant_a || grant_b;
    d_addr_d      = d_addr_q;
    d_data_d      = d_data_q;

    if (grant_a) begin
      slot_a_full_d = 1'b0;
      d_addr_d      = slot_a_addr_q;
      d_data_d      = slot_a_data_q;
      last_grant_d  = GRANT_A;
    end else if (grant_b) begin
      slot_b_full_d = 1'b0;
      d_addr_d      = slot_b_addr_q;
      d_data_d      = slot_b_data_q;
      last_grant_d  = GRANT_B;
    end

    // An accept overrides the grant's clear.  An r0 request leaves the slot
    // empty.
    if (accept_a) begin
      slot_a_full_d = (a_addr != '0);
      slot_a_addr_d = a_addr;
      slot_a_data_d = a_data;
    end
    if (accept_b) begin
      slot_b_full_d = (b_addr != '0);
      slot_b_addr_d = b_addr;
      slot_b_data_d = b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_a_full_q <= 1'b0;
      slot_a_addr_q <= '0;
      slot_a_data_q <= '0;
      slot_b_full_q <= 1'b0;
      slot_b_addr_q <= '0;
      slot_b_data_q <= '0;
      last_grant_q  <= GRANT_B;
      d_en_q        <= 1'b0;
      d_addr_q      <= '0;
      d_data_q      <= '0;
    end else begin
      slot_a_full_q <= slot_a_full_d;
      slot_a_addr_q <= slot_a_addr_d;
      slot_a_data_q <= slot_a_data_d;
      slot_b_full_q <= slot_b_full_d;
      slot_b_addr_q <= slot_b_addr_d;
      slot_b_data_q <= slot_b_data_d;
      last_grant_q  <= last_grant_d;
      d_en_q        <= d_en_d;
      d_addr_q      <= d_addr_d;
      d_data_q      <= d_data_d;
    end
  end

  assign D_En   = d_en_q;
  assign D_Addr = d_addr_q;
  assign D      = d_data_q;
  assign idle   = !slot_a_full_q && !slot_b_full_q && !d_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Scoreboard bench for regfile_wr_arbiter.
//
// A reference model tracks each requester's pending write as a 0/1-entry
// queue.  On every edge it pushes the write that should issue onto an
// expected queue.  A monitor pops that queue whenever the DUT shows D_En.
// The monitor also checks the hold behaviour, ready, idle and the
// asynchronous reset values.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        D_En;
  logic [4:0]  D_Addr;
  logic [31:0] D;
  logic        idle;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_addr (b_addr),
    .b_data (b_data),
    .D_En   (D_En),
    .D_Addr (D_Addr),
    .D      (D),
    .idle   (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  wr_t pend_a[$];
  wr_t pend_b[$];
  wr_t exp_q[$];
  bit  b_won_last;
  bit  exp_a_ready, exp_b_ready, exp_idle;

  // The model decides whether A wins the write port this cycle.
  function automatic bit a_wins(input bit has_a, input bit has_b, input bit b_last);
`ifdef RFARB_FIXED_PRIO_EN
    return has_a;
`else
    if (!has_a) return 1'b0;
    if (!has_b) return 1'b1;
    return b_last;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_a.delete();
      pend_b.delete();
      b_won_last  = 1'b1;
      exp_a_ready = 1'b1;
      exp_b_ready = 1'b1;
      exp_idle    = 1'b1;
    end else begin
      bit  wa, wb, ta, tb, issued;
      wr_t w;
      wa = a_wins(pend_a.size() != 0, pend_b.size() != 0, b_won_last);
      wb = !wa && (pend_b.size() != 0);
      ta = a_valid && ((pend_a.size() == 0) || wa);
      tb = b_valid && ((pend_b.size() == 0) || wb);
      issued = wa || wb;
      if (wa) begin
        exp_q.push_back(pend_a.pop_front());
        b_won_last = 1'b0;
      end else if (wb) begin
        exp_q.push_back(pend_b.pop_front());
        b_won_last = 1'b1;
      end
      if (ta && a_addr != 5'd0) begin
        w.addr = a_addr;
        w.data = a_data;
        pend_a.push_back(w);
      end
      if (tb && b_addr != 5'd0) begin
        w.addr = b_addr;
        w.data = b_data;
        pend_b.push_back(w);
      end
      wa = a_wins(pend_a.size() != 0, pend_b.size() != 0, b_won_last);
      wb = !wa && (pend_b.size() != 0);
      exp_a_ready = (pend_a.size() == 0) || wa;
      exp_b_ready = (pend_b.size() == 0) || wb;
      exp_idle    = (pend_a.size() == 0) && (pend_b.size() == 0) && !issued;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  logic [4:0]  hold_addr;
  logic [31:0] hold_data;

  initial begin
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #1;
        chk("rst_D_En",    {63'd0, D_En}, 64'd0);
        chk("rst_D_Addr",  {59'd0, D_Addr}, 64'd0);
        chk("rst_D",       {32'd0, D}, 64'd0);
        chk("rst_a_ready", {63'd0, a_ready}, 64'd1);
        chk("rst_b_ready", {63'd0, b_ready}, 64'd1);
        chk("rst_idle",    {63'd0, idle}, 64'd1);
        exp_q.delete();
        hold_addr = '0;
        hold_data = '0;
      end else begin
        if (D_En) begin
          chk("write_was_expected", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            wr_t w;
            w = exp_q.pop_front();
            chk("D_Addr", {59'd0, D_Addr}, {59'd0, w.addr});
            chk("D",      {32'd0, D}, {32'd0, w.data});
            hold_addr = w.addr;
            hold_data = w.data;
          end
        end else begin
          chk("missing_write", exp_q.size(), 64'd0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          chk("D_Addr_hold", {59'd0, D_Addr}, {59'd0, hold_addr});
          chk("D_hold",      {32'd0, D}, {32'd0, hold_data});
        end
        chk("a_ready", {63'd0, a_ready}, {63'd0, exp_a_ready});
        chk("b_ready", {63'd0, b_ready}, {63'd0, exp_b_ready});
        chk("idle",    {63'd0, idle}, {63'd0, exp_idle});
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [4:0] rand_addr(input bit allow_zero);
    return allow_zero ? 5'($urandom_range(31)) : 5'($urandom_range(31, 1));
  endfunction

  // Runs n cycles.  A request is held until its handshake completes.  Each
  // requester then presents a new request with probability pa/pb percent.
  task automatic drive(input int n, input int pa, input int pb, input bit allow_zero);
    bit acc_a, acc_b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (!a_valid || acc_a) begin
        if (int'($urandom_range(99)) < pa) begin
          a_valid = 1'b1;
          a_addr  = rand_addr(allow_zero);
          a_data  = $urandom;
        end else begin
          a_valid = 1'b0;
        end
      end
      if (!b_valid || acc_b) begin
        if (int'($urandom_range(99)) < pb) begin
          b_valid = 1'b1;
          b_addr  = rand_addr(allow_zero);
          b_data  = $urandom;
        end else begin
          b_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    a_data  = '0;
    b_data  = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic write.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    drive(5, 0, 0, 1'b0);

    // Simultaneous first requests.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
    drive(5, 0, 0, 1'b0);

    // Sustained contention.
    drive(8, 100, 100, 1'b0);
    drive(6, 0, 0, 1'b0);

    // r0 drop.
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
    drive(4, 0, 0, 1'b0);

    // Same address in both slots.
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB9;
    drive(5, 0, 0, 1'b0);

    // Reset mid-operation, while a write is on the port and both slots hold entries.
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
    drive(1, 0, 0, 1'b0);
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h1010;
    drive(1, 0, 0, 1'b0);
    #2;
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    drive(5, 0, 0, 1'b0);

`ifdef RFARB_FIXED_PRIO_EN
    // Fixed priority: B starves while A stays busy.
    drive(6, 100, 100, 1'b0);
    a_valid = 1'b0;
    drive(6, 0, 0, 1'b0);
`endif

    // Randomized traffic, including r0 requests.
    drive(300, 60, 60, 1'b1);
    drive(400, 0, 0, 1'b1);
    drive(6, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the 32x32 register file. Two independent writeback sources (requester A, e.g. ALU writeback; requester B, e.g. load/multi-cycle unit writeback) share the single register-file write port. Each requester has a one-entry holding slot with a valid/ready handshake, and a round-robin arbiter drains the slots onto the registered `D_En` / `D_Addr` / `D` write-port outputs at one write per cycle.

## Interface
- `DATA_W`, 32, data width of every write.
- `ADDR_W`, 5, register address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `a_valid`  in  1  requester A presents a write.
- `a_ready`  out  1  A's slot can accept this cycle.
- `a_addr`  in  ADDR_W  A's destination register.
- `a_data`  in  DATA_W  A's write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`  same as A, for requester B.
- `D_En`  out  1  write enable to the register file.
- `D_Addr`  out  ADDR_W  write address to the register file.
- `D`  out  DATA_W  write data to the register file.
- `idle`  out  1  both slots empty and `D_En` low.

## Operation
- State: `slot_a_full`, `slot_b_full`, each with stored addr and data; `last_grant` (0 = A, 1 = B); registered `D_En`, `D_Addr`, `D`.
- Accept: on a rising edge with `x_valid && x_ready`, capture `x_addr` / `x_data` into slot x.
  - If `x_addr == 0`, the request is accepted but dropped. The slot stays empty and no write is issued, because r0 is never written.
- `x_ready = !slot_x_full || grant_x`. This allows a new accept in the same cycle the held entry is granted, so back-to-back writes run at full rate.
- Grant (combinational, from slot state):
  - Only A full: grant A.
  - Only B full: grant B.
  - Both full: grant the slot not equal to `last_grant`.
- On a grant edge:
  - `D_En <= 1`, `D_Addr` / `D` take the granted slot's contents.
  - The granted slot is cleared, unless it is refilled by a same-edge accept.
  - `last_grant` takes the granted slot.
- With no grant: `D_En <= 0`, and `D_Addr` / `D` hold their previous values.
- Same address held in both slots: both writes are issued in grant order, so the later-granted write is the one the register file keeps. No merging.
- Reset mid-operation: held entries are discarded and not replayed. Requesters re-issue after reset.

## Timing
- Reset values: `D_En = 0`, `D_Addr = 0`, `D = 0`, both slots empty, `last_grant = 1` (A wins first), `a_ready = b_ready = 1`, `idle = 1`.
- Latency: accepted at edge E0, slot full after E0, granted at E1, `D_En` high during the cycle after E1, register file writes at E2. That is 2 edges from accept to register-file write.
- `D_En` is high for exactly one cycle per issued write.
- Throughput: one write per cycle aggregate. Under continuous contention, each requester gets one write every 2 cycles.
- Stall: a slot that is full and not granted deasserts its `x_ready`. The requester must hold `x_valid`, `x_addr` and `x_data` stable until accepted.
- No combinational path from `x_valid` to `x_ready`. The `x_ready` outputs depend only on registered state.

## Configuration
- `RFARB_FIXED_PRIO_EN`
  - Defined: fixed priority. A always wins when both slots are full; `last_grant` is still updated but ignored. Continuous A traffic may starve B.
  - Undefined (default): round-robin as specified above.

## Test plan
- Basic write: after reset, A sends addr 3, data 0xDEADBEEF for one cycle. Required: `D_En` is high for one cycle, two edges later, with `D_Addr = 3` and `D = 0xDEADBEEF`; `idle` returns to 1.
- Simultaneous first requests: A (addr 5, 0x11) and B (addr 6, 0x22) are valid in the same cycle after reset. Required: A's write issues first, B's write issues the next cycle, and `b_ready` is low for one cycle.
- Sustained contention: A and B are both continuously valid for 8 cycles. Required:
  - Issued writes alternate A, B, A, B…
  - `D_En` is high every cycle once the pipe fills.
  - No request is lost or duplicated.
- r0 drop: A sends addr 0, data 0xFFFFFFFF. Required: accepted (`a_ready` = 1), `D_En` never rises, `idle` stays 1.
- Reset mid-operation: fill both slots, then assert `reset` mid-cycle. Required:
  - `D_En`, `D_Addr` and `D` are 0 immediately, without waiting for a clock edge.
  - No writes issue after reset deasserts.
  - `a_ready = b_ready = 1`.
- Fixed priority, with `RFARB_FIXED_PRIO_EN` defined: A and B are both continuously valid for 6 cycles. Required: only A writes issue and `b_ready` stays low. After A drops `a_valid`, B's write issues on the next grant.
